// File: rtl/fifo_ram.sv
// Simple dual-port W x 2^LOGD storage for fifo_flags: one synchronous
// write port and one read port whose timing depends on FWFT.
module fifo_ram #(
    parameter int W    = 8,
    parameter int LOGD = 7,
    parameter bit FWFT = 1'b1
) (
    input  logic            clk,
    input  logic            i_reset_n,
    input  logic            i_wr_en,
    input  logic [LOGD-1:0] i_wr_addr,
    input  logic [W-1:0]    i_wr_data,
    input  logic            i_rd_en,
    input  logic [LOGD-1:0] i_rd_addr,
    output logic [W-1:0]    o_rd_data
);

    localparam int DEPTH = 1 << LOGD;

    logic [W-1:0] mem [DEPTH];

    // Storage array is deliberately left unreset so it can map onto RAM cells.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is shown as soon as the read address points at it.
            assign o_rd_data = mem[i_rd_addr];

            logic unused_rd_ctrl;
            assign unused_rd_ctrl = &{1'b0, i_rd_en, i_reset_n};
        end else begin : g_registered
            logic [W-1:0] rd_data_d;
            logic [W-1:0] rd_data_q;

            // Capture the addressed word only on an accepted read, otherwise hold.
            always_comb begin
                rd_data_d = rd_data_q;
                if (i_rd_en) begin
                    rd_data_d = mem[i_rd_addr];
                end
            end

            // Output register clears on reset so o_data starts at zero.
            always_ff @(posedge clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    rd_data_q <= '0;
                end else begin
                    rd_data_q <= rd_data_d;
                end
            end

            assign o_rd_data = rd_data_q;
        end
    endgenerate

endmodule

// File: rtl/fifo_flags.sv
// Single-clock byte FIFO with fill count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a synchronous flush.
// Pointers carry one extra bit so all 2^LOGD entries are usable.
module fifo_flags #(
    parameter int W         = 8,
    parameter int LOGD      = 7,
    parameter int AFULL_TH  = (1 << LOGD) - 4,
    parameter int AEMPTY_TH = 4,
    parameter bit FWFT      = 1'b1
) (
    input  logic            clk,
    input  logic            i_reset_n,
    input  logic            i_clr,
    input  logic            i_wr,
    input  logic            i_rd,
    input  logic [W-1:0]    i_data,
    output logic [W-1:0]    o_data,
    output logic            o_valid,
    output logic [LOGD:0]   o_count,
    output logic            o_full,
    output logic            o_empty,
    output logic            o_afull,
    output logic            o_aempty,
    output logic            o_overflow,
    output logic            o_underflow
);

    localparam int DEPTH = 1 << LOGD;
    localparam int PW    = LOGD + 1;

    logic [PW-1:0] wr_ptr_d, wr_ptr_q;
    logic [PW-1:0] rd_ptr_d, rd_ptr_q;
    logic          overflow_d, overflow_q;
    logic          underflow_d, underflow_q;
    logic [PW-1:0] count;
    logic          rd_ok;
    logic          wr_ok;

    // Status is derived from the registered pointers only.
    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        o_count  = count;
        o_full   = (count == PW'(DEPTH));
        o_empty  = (count == '0);
        o_afull  = (count >= PW'(AFULL_TH));
        o_aempty = (count <= PW'(AEMPTY_TH));
    end

    // Accept decisions; a full FIFO still takes a write when a read frees a slot.
    always_comb begin
        rd_ok = !i_clr && i_rd && !o_empty;
        wr_ok = !i_clr && i_wr && (!o_full || rd_ok);
    end

    // Next-state for pointers and sticky flags; flush overrides everything.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (i_clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (i_wr && !wr_ok) begin
                overflow_d = 1'b1;
            end
            if (i_rd && !rd_ok) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Control state registers with immediate reset.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;

    fifo_ram #(
        .W    (W),
        .LOGD (LOGD),
        .FWFT (FWFT)
    ) u_ram (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .i_wr_en   (wr_ok),
        .i_wr_addr (wr_ptr_q[LOGD-1:0]),
        .i_wr_data (i_data),
        .i_rd_en   (rd_ok),
        .i_rd_addr (rd_ptr_q[LOGD-1:0]),
        .o_rd_data (o_data)
    );

    generate
        if (FWFT) begin : g_valid_fwft
            assign o_valid = !o_empty;
        end else begin : g_valid_reg
            logic valid_d, valid_q;

            // Valid pulses for exactly the cycle after an accepted read.
            always_comb begin
                valid_d = rd_ok;
            end

            // Valid register, cleared on reset.
            always_ff @(posedge clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= valid_d;
                end
            end

            assign o_valid = valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_flags.sv
// Self-checking bench for fifo_flags: a FWFT instance and a registered-read
// instance share stimulus and are compared against a queue-based model.
module tb_fifo_flags;

    localparam int W     = 8;
    localparam int LOGD  = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic         clk = 1'b0;
    logic         i_reset_n = 1'b0;
    logic         i_clr = 1'b0;
    logic         i_wr = 1'b0;
    logic         i_rd = 1'b0;
    logic [W-1:0] i_data = '0;

    logic [W-1:0] data_f, data_r;
    logic         valid_f, valid_r;
    logic [LOGD:0] count_f, count_r;
    logic         full_f, full_r, empty_f, empty_r;
    logic         afull_f, afull_r, aempty_f, aempty_r;
    logic         ovf_f, ovf_r, unf_f, unf_r;

    int errors = 0;
    int checks = 0;

    logic [7:0] q [$];
    bit         ovf_m, unf_m;
    bit         reg_valid_m;
    logic [7:0] reg_data_m;

    always #5 clk = ~clk;

    fifo_flags #(.W(W), .LOGD(LOGD), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1'b1)) u_fwft (
        .clk(clk), .i_reset_n(i_reset_n), .i_clr(i_clr), .i_wr(i_wr), .i_rd(i_rd),
        .i_data(i_data), .o_data(data_f), .o_valid(valid_f), .o_count(count_f),
        .o_full(full_f), .o_empty(empty_f), .o_afull(afull_f), .o_aempty(aempty_f),
        .o_overflow(ovf_f), .o_underflow(unf_f)
    );

    fifo_flags #(.W(W), .LOGD(LOGD), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1'b0)) u_reg (
        .clk(clk), .i_reset_n(i_reset_n), .i_clr(i_clr), .i_wr(i_wr), .i_rd(i_rd),
        .i_data(i_data), .o_data(data_r), .o_valid(valid_r), .o_count(count_r),
        .o_full(full_r), .o_empty(empty_r), .o_afull(afull_r), .o_aempty(aempty_r),
        .o_overflow(ovf_r), .o_underflow(unf_r)
    );

    task automatic model_reset();
        q.delete();
        ovf_m = 0;
        unf_m = 0;
        reg_valid_m = 0;
        reg_data_m = 8'h00;
    endtask

    // One clock of stimulus; the model applies the FIFO rules at the edge.
    task automatic step(input bit clr, input bit wr, input bit rd, input logic [7:0] d);
        bit rd_ok, wr_ok;
        @(negedge clk);
        i_clr = clr; i_wr = wr; i_rd = rd; i_data = d;
        @(posedge clk);
        if (clr) begin
            q.delete();
            ovf_m = 0; unf_m = 0; reg_valid_m = 0;
        end else begin
            rd_ok = rd && (q.size() > 0);
            wr_ok = wr && ((q.size() < DEPTH) || rd_ok);
            if (rd && !rd_ok) unf_m = 1;
            if (wr && !wr_ok) ovf_m = 1;
            reg_valid_m = rd_ok;
            if (rd_ok) reg_data_m = q.pop_front();
            if (wr_ok) q.push_back(d);
        end
        #1;
        i_clr = 0; i_wr = 0; i_rd = 0;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (count_f !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d exp=0", count_f); end
        checks++; if ({empty_f, full_f, aempty_f, afull_f} !== 4'b1010) begin errors++; $display("[TB] FAIL reset_status got=%b exp=1010", {empty_f, full_f, aempty_f, afull_f}); end
        checks++; if ({ovf_f, unf_f, valid_f, valid_r} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags got=%b exp=0000", {ovf_f, unf_f, valid_f, valid_r}); end
        checks++; if (data_r !== 8'h00) begin errors++; $display("[TB] FAIL reset_data_reg got=%h exp=00", data_r); end
        @(negedge clk);
        i_reset_n = 1'b1;
    endtask

    task automatic test_fill();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, vals[i]);
            checks++; if (count_f !== 3'(i + 1)) begin errors++; $display("[TB] FAIL fill_count got=%0d exp=%0d", count_f, i + 1); end
            checks++; if (afull_f !== (i + 1 >= AF)) begin errors++; $display("[TB] FAIL fill_afull got=%b exp=%b", afull_f, (i + 1 >= AF)); end
            checks++; if (aempty_f !== (i + 1 <= AE)) begin errors++; $display("[TB] FAIL fill_aempty got=%b exp=%b", aempty_f, (i + 1 <= AE)); end
            checks++; if (full_f !== (i == 3)) begin errors++; $display("[TB] FAIL fill_full got=%b exp=%b", full_f, (i == 3)); end
            checks++; if (ovf_f !== 1'b0) begin errors++; $display("[TB] FAIL fill_ovf got=%b exp=0", ovf_f); end
        end
    endtask

    task automatic test_overflow();
        step(0, 1, 0, 8'h55);
        checks++; if (ovf_f !== 1'b1 || ovf_r !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set got=%b%b exp=11", ovf_f, ovf_r); end
        checks++; if (count_f !== 3'd4) begin errors++; $display("[TB] FAIL ovf_count got=%0d exp=4", count_f); end
        checks++; if (data_f !== 8'h11) begin errors++; $display("[TB] FAIL full_head got=%h exp=11", data_f); end
        step(0, 1, 1, 8'h66);
        checks++; if (count_f !== 3'd4 || full_f !== 1'b1) begin errors++; $display("[TB] FAIL full_rw_count got=%0d/%b exp=4/1", count_f, full_f); end
        checks++; if (valid_r !== 1'b1 || data_r !== 8'h11) begin errors++; $display("[TB] FAIL full_rw_read got=%b/%h exp=1/11", valid_r, data_r); end
    endtask

    task automatic test_drain();
        logic [7:0] exp [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
        for (int i = 0; i < 4; i++) begin
            checks++; if (valid_f !== 1'b1 || data_f !== exp[i]) begin errors++; $display("[TB] FAIL drain_head got=%b/%h exp=1/%h", valid_f, data_f, exp[i]); end
            step(0, 0, 1, 8'h00);
            checks++; if (data_r !== exp[i]) begin errors++; $display("[TB] FAIL drain_reg got=%h exp=%h", data_r, exp[i]); end
        end
        step(0, 0, 1, 8'h00);
        checks++; if (unf_f !== 1'b1 || unf_r !== 1'b1) begin errors++; $display("[TB] FAIL unf_set got=%b%b exp=11", unf_f, unf_r); end
        checks++; if (count_f !== 3'd0 || valid_f !== 1'b0 || valid_r !== 1'b0) begin errors++; $display("[TB] FAIL unf_state got=%0d/%b/%b exp=0/0/0", count_f, valid_f, valid_r); end
    endtask

    task automatic test_registered_read();
        step(0, 1, 0, 8'hA5);
        checks++; if (valid_r !== 1'b0 || data_r !== 8'h66) begin errors++; $display("[TB] FAIL reg_prewrite got=%b/%h exp=0/66", valid_r, data_r); end
        step(0, 0, 1, 8'h00);
        checks++; if (valid_r !== 1'b1 || data_r !== 8'hA5) begin errors++; $display("[TB] FAIL reg_read got=%b/%h exp=1/a5", valid_r, data_r); end
        step(0, 0, 0, 8'h00);
        checks++; if (valid_r !== 1'b0 || data_r !== 8'hA5) begin errors++; $display("[TB] FAIL reg_hold got=%b/%h exp=0/a5", valid_r, data_r); end
    endtask

    task automatic test_wrap();
        step(0, 1, 0, 8'h00);
        for (int i = 1; i <= 10; i++) begin
            checks++; if (data_f !== 8'(i - 1)) begin errors++; $display("[TB] FAIL wrap_head got=%h exp=%h", data_f, 8'(i - 1)); end
            step(0, i < 10, 1, 8'(i));
            checks++; if (valid_r !== 1'b1 || data_r !== 8'(i - 1)) begin errors++; $display("[TB] FAIL wrap_reg got=%b/%h exp=1/%h", valid_r, data_r, 8'(i - 1)); end
            checks++; if (count_f > 3'd2) begin errors++; $display("[TB] FAIL wrap_count got=%0d exp<=2", count_f); end
        end
        checks++; if (empty_f !== 1'b1) begin errors++; $display("[TB] FAIL wrap_empty got=%b exp=1", empty_f); end
    endtask

    task automatic test_clear_and_reset();
        step(0, 1, 0, 8'h01);
        step(0, 1, 0, 8'h02);
        step(0, 1, 0, 8'h03);
        step(0, 1, 0, 8'h04);
        step(0, 1, 0, 8'h05);
        step(0, 0, 1, 8'h00);
        checks++; if (count_f !== 3'd3 || ovf_f !== 1'b1 || unf_f !== 1'b1) begin errors++; $display("[TB] FAIL clr_pre got=%0d/%b/%b exp=3/1/1", count_f, ovf_f, unf_f); end
        step(1, 1, 0, 8'h77);
        checks++; if (count_f !== 3'd0 || empty_f !== 1'b1) begin errors++; $display("[TB] FAIL clr_count got=%0d/%b exp=0/1", count_f, empty_f); end
        checks++; if ({ovf_f, unf_f, ovf_r, unf_r, valid_f, valid_r} !== 6'b0) begin errors++; $display("[TB] FAIL clr_flags got=%b exp=000000", {ovf_f, unf_f, ovf_r, unf_r, valid_f, valid_r}); end
        step(0, 1, 0, 8'h10);
        step(0, 1, 1, 8'h20);
        step(0, 1, 0, 8'h30);
        @(negedge clk);
        i_wr = 1'b1; i_data = 8'h40;
        #2;
        i_reset_n = 1'b0;
        #1;
        checks++; if (count_f !== 3'd0 || count_r !== 3'd0) begin errors++; $display("[TB] FAIL rst_mid_count got=%0d/%0d exp=0/0", count_f, count_r); end
        checks++; if ({empty_f, full_f, aempty_f, afull_f} !== 4'b1010) begin errors++; $display("[TB] FAIL rst_mid_status got=%b exp=1010", {empty_f, full_f, aempty_f, afull_f}); end
        checks++; if ({ovf_f, unf_f, valid_f, valid_r} !== 4'b0 || data_r !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_out got=%b/%h exp=0000/00", {ovf_f, unf_f, valid_f, valid_r}, data_r); end
        model_reset();
        @(negedge clk);
        i_wr = 1'b0;
        i_reset_n = 1'b1;
    endtask

    task automatic test_random();
        bit c, w, r;
        int n;
        for (int k = 0; k < 400; k++) begin
            c = ($urandom_range(0, 19) == 0);
            w = $urandom_range(0, 1);
            r = $urandom_range(0, 1);
            step(c, w, r, 8'($urandom));
            n = q.size();
            checks++; if (count_f !== 3'(n) || count_r !== 3'(n)) begin errors++; $display("[TB] FAIL rnd_count got=%0d/%0d exp=%0d", count_f, count_r, n); end
            checks++; if ({full_f, empty_f, afull_f, aempty_f} !== {n == DEPTH, n == 0, n >= AF, n <= AE}) begin errors++; $display("[TB] FAIL rnd_status got=%b exp=%b", {full_f, empty_f, afull_f, aempty_f}, {n == DEPTH, n == 0, n >= AF, n <= AE}); end
            checks++; if ({ovf_f, unf_f, ovf_r, unf_r} !== {ovf_m, unf_m, ovf_m, unf_m}) begin errors++; $display("[TB] FAIL rnd_sticky got=%b exp=%b", {ovf_f, unf_f, ovf_r, unf_r}, {ovf_m, unf_m, ovf_m, unf_m}); end
            checks++; if (valid_f !== (n > 0) || (n > 0 && data_f !== q[0])) begin errors++; $display("[TB] FAIL rnd_fwft got=%b/%h exp=%b/%h", valid_f, data_f, (n > 0), (n > 0) ? q[0] : 8'h00); end
            checks++; if (valid_r !== reg_valid_m || data_r !== reg_data_m) begin errors++; $display("[TB] FAIL rnd_reg got=%b/%h exp=%b/%h", valid_r, data_r, reg_valid_m, reg_data_m); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_registered_read();
        test_wrap();
        test_clear_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
